// File: rtl/stm32_readback.sv
// stm32_readback: halts the CPU, takes memory port 2 and streams DEPTH bytes to the STM32 over a VALID/ACK bus.
// Define READBACK_CHECKSUM_EN to append a mod-256 sum of the streamed bytes as a final byte.
module stm32_readback #(
  parameter logic [31:0] START_ADDR = 32'd0,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  progCtl,
  output logic [9:0]  progOut,
  input  logic        cpu_RST,
  input  logic        memWrite,
  input  logic        memRead2,
  input  logic [31:0] addr2,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] memDout2,
  output logic        prog_RST,
  output logic        prog_memWrite,
  output logic        prog_memRead2,
  output logic [31:0] prog_addr2,
  output logic [1:0]  prog_size,
  output logic        prog_sign
);

  localparam int unsigned     LW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0]   LAT_INIT = LW'(MEM_LAT - 1);
  localparam logic [LW-1:0]   LAT_ONE  = LW'(1);
  localparam logic [31:0]     LAST     = 32'(DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_ACKED,
    S_NEXT,
    S_DONE,
`ifdef READBACK_CHECKSUM_EN
    S_CSUM,
    S_CSUM_ACKED,
`endif
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          ack_q;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic req, ack, ack_rise;
  logic unused_dout_hi;

  assign req            = progCtl[0];
  assign ack            = progCtl[1];
  // ACK must be seen rising in PRESENT, so a level held over from an earlier byte or a reset cannot take a byte
  assign ack_rise       = ack & ~ack_q;
  assign unused_dout_hi = ^memDout2[31:8];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      ack_q   <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
      ack_q   <= ack;
`ifdef READBACK_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    lat_d   = lat_q;
`ifdef READBACK_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    // Dropping REQ anywhere in a transfer is both the abort and the normal exit from DONE
    if (!req && state_q != S_IDLE && state_q != S_RELEASE) begin
      state_d = S_RELEASE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef READBACK_CHECKSUM_EN
          sum_d = '0;
`endif
          if (req) state_d = S_READ;
        end
        S_READ: begin
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == '0) begin
            data_d  = memDout2[7:0];
`ifdef READBACK_CHECKSUM_EN
            sum_d   = sum_q + memDout2[7:0];
`endif
            state_d = S_PRESENT;
          end else begin
            lat_d = lat_q - LAT_ONE;
          end
        end
        S_PRESENT: if (ack_rise) state_d = S_ACKED;
        S_ACKED:   if (!ack) state_d = S_NEXT;
        S_NEXT: begin
          if (cnt_q == LAST) begin
`ifdef READBACK_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d   = cnt_q + 32'd1;
            state_d = S_READ;
          end
        end
`ifdef READBACK_CHECKSUM_EN
        S_CSUM:       if (ack_rise) state_d = S_CSUM_ACKED;
        S_CSUM_ACKED: if (!ack) state_d = S_DONE;
`endif
        S_RELEASE: begin
          cnt_d   = '0;
`ifdef READBACK_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    prog_RST      = 1'b1;
    prog_memWrite = 1'b0;
    prog_memRead2 = 1'b0;
    prog_addr2    = START_ADDR + cnt_q;
    prog_size     = 2'b00;
    prog_sign     = 1'b0;
    progOut       = {2'b00, data_q};
    case (state_q)
      S_IDLE: begin
        prog_RST      = cpu_RST;
        prog_memWrite = memWrite;
        prog_memRead2 = memRead2;
        prog_addr2    = addr2;
        prog_size     = size;
        prog_sign     = sign;
        progOut       = '0;
      end
      S_READ:    prog_memRead2 = 1'b1;
      S_PRESENT: progOut[8] = 1'b1;
      S_DONE:    progOut[9] = 1'b1;
`ifdef READBACK_CHECKSUM_EN
      S_CSUM:       progOut = {2'b01, sum_q};
      S_CSUM_ACKED: progOut = {2'b00, sum_q};
`endif
      S_RELEASE: progOut = '0;
      default:   progOut = {2'b00, data_q};
    endcase
  end

endmodule

// File: tb/tb_stm32_readback.sv
// Bench for stm32_readback: two instances (MEM_LAT 1 and 3) checked every cycle against a transaction-level model.
module tb_stm32_readback;

  localparam logic [31:0] START = 32'd0;
  localparam int DEPTH = 3;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
`ifdef READBACK_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int NBYTES = DEPTH + CSUM;
  localparam int M_IDLE = 0, M_XFER = 1, M_DONE = 2, M_REL = 3;
  localparam int P_FETCH = 0, P_SHOW = 1, P_TAKEN = 2, P_GAP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ctl [2];
  logic cpu_rst, mw, mr2, sg;
  logic [31:0] a2;
  logic [1:0] sz;
  logic [31:0] dout [2];
  logic [9:0] pout [2];
  logic p_rst [2], p_mw [2], p_mr [2], p_sg [2];
  logic [31:0] p_a [2];
  logic [1:0] p_sz [2];

  always #5 clk = ~clk;

  stm32_readback #(.START_ADDR(START), .DEPTH(DEPTH), .MEM_LAT(LAT0)) u_dut0 (
    .CLK(clk), .RST(rst_n), .progCtl(ctl[0]), .progOut(pout[0]),
    .cpu_RST(cpu_rst), .memWrite(mw), .memRead2(mr2), .addr2(a2), .size(sz), .sign(sg),
    .memDout2(dout[0]), .prog_RST(p_rst[0]), .prog_memWrite(p_mw[0]), .prog_memRead2(p_mr[0]),
    .prog_addr2(p_a[0]), .prog_size(p_sz[0]), .prog_sign(p_sg[0]));

  stm32_readback #(.START_ADDR(START), .DEPTH(DEPTH), .MEM_LAT(LAT1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .progCtl(ctl[1]), .progOut(pout[1]),
    .cpu_RST(cpu_rst), .memWrite(mw), .memRead2(mr2), .addr2(a2), .size(sz), .sign(sg),
    .memDout2(dout[1]), .prog_RST(p_rst[1]), .prog_memWrite(p_mw[1]), .prog_memRead2(p_mr[1]),
    .prog_addr2(p_a[1]), .prog_size(p_sz[1]), .prog_sign(p_sg[1]));

  // Memory: the read strobe's byte appears exactly MEM_LAT cycles later, random junk on every other cycle
  logic [7:0] mem [16];
  logic pv [2][3];
  logic [3:0] pa [2][3];
  logic [31:0] garb [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pv[k][0] <= p_mr[k];
      pa[k][0] <= p_a[k][3:0];
      for (int i = 1; i < 3; i++) begin
        pv[k][i] <= pv[k][i-1];
        pa[k][i] <= pa[k][i-1];
      end
      garb[k] <= $urandom;
    end
  end
  assign dout[0] = pv[0][LAT0-1] ? {24'h0, mem[pa[0][LAT0-1]]} : garb[0];
  assign dout[1] = pv[1][LAT1-1] ? {24'h0, mem[pa[1][LAT1-1]]} : garb[1];

  int n_chk = 0;
  int n_fail = 0;
  int n = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, got, exp, n);
    end
  endfunction

  // Transaction model: mode of the block, which byte is in flight, and when its READ happened
  int m_mode [2];
  int m_ph [2];
  int m_idx [2];
  int m_rd [2];
  logic [7:0] m_dat [2];
  logic [7:0] m_sum [2];
  bit m_ackp [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_ph[k] = P_FETCH; m_idx[k] = 0; m_rd[k] = 0;
      m_dat[k] = 8'h0; m_sum[k] = 8'h0; m_ackp[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    n++;
    for (int k = 0; k < 2; k++) begin
      bit req, ack;
      int lat;
      req = ctl[k][0];
      ack = ctl[k][1];
      lat = (k == 0) ? LAT0 : LAT1;
      if (!rst_n) begin
        m_mode[k] = M_IDLE;
      end else if (m_mode[k] == M_IDLE) begin
        if (req) begin
          m_mode[k] = M_XFER; m_ph[k] = P_FETCH; m_idx[k] = 0; m_rd[k] = n; m_sum[k] = 8'h0;
        end
      end else if (m_mode[k] == M_REL) begin
        m_mode[k] = M_IDLE;
      end else if (!req) begin
        m_mode[k] = M_REL;
      end else if (m_mode[k] == M_XFER) begin
        case (m_ph[k])
          P_FETCH: if (n == m_rd[k] + lat + 1) begin
            m_dat[k] = mem[(START + 32'(m_idx[k])) % 16];
            m_sum[k] = m_sum[k] + m_dat[k];
            m_ph[k] = P_SHOW;
          end
          P_SHOW: if (ack && !m_ackp[k]) m_ph[k] = P_TAKEN;
          P_TAKEN: if (!ack) begin
            if (m_idx[k] == DEPTH) m_mode[k] = M_DONE;
            else m_ph[k] = P_GAP;
          end
          default: begin
            if (m_idx[k] == DEPTH - 1) begin
              if (CSUM != 0) begin
                m_idx[k] = DEPTH; m_dat[k] = m_sum[k]; m_ph[k] = P_SHOW;
              end else begin
                m_mode[k] = M_DONE;
              end
            end else begin
              m_idx[k]++; m_ph[k] = P_FETCH; m_rd[k] = n;
            end
          end
        endcase
      end
      m_ackp[k] = rst_n && ack;
    end
  end

  always @(negedge clk) begin
    if (n > 0) begin
      for (int k = 0; k < 2; k++) begin
        if (m_mode[k] == M_IDLE) begin
          chk("pass_rst", 32'(p_rst[k]), 32'(cpu_rst));
          chk("pass_wr", 32'(p_mw[k]), 32'(mw));
          chk("pass_rd", 32'(p_mr[k]), 32'(mr2));
          chk("pass_addr", p_a[k], a2);
          chk("pass_size", 32'(p_sz[k]), 32'(sz));
          chk("pass_sign", 32'(p_sg[k]), 32'(sg));
          chk("idle_out", 32'(pout[k]), 32'h0);
        end else begin
          chk("own_rst", 32'(p_rst[k]), 32'h1);
          chk("own_wr", 32'(p_mw[k]), 32'h0);
          chk("own_size", 32'(p_sz[k]), 32'h0);
          chk("own_sign", 32'(p_sg[k]), 32'h0);
          if (m_mode[k] == M_REL) begin
            chk("rel_out", 32'(pout[k]), 32'h0);
            chk("rel_rd", 32'(p_mr[k]), 32'h0);
          end else if (m_mode[k] == M_DONE) begin
            chk("done_flags", 32'(pout[k][9:8]), 32'h2);
            chk("done_rd", 32'(p_mr[k]), 32'h0);
            chk("done_addr", p_a[k], START + 32'(DEPTH - 1));
          end else begin
            chk("addr", p_a[k], START + 32'((m_idx[k] >= DEPTH) ? DEPTH - 1 : m_idx[k]));
            chk("rd_strobe", 32'(p_mr[k]), 32'(m_ph[k] == P_FETCH && n == m_rd[k]));
            chk("flags", 32'(pout[k][9:8]), 32'(m_ph[k] == P_SHOW));
            if (m_ph[k] == P_SHOW || m_ph[k] == P_TAKEN)
              chk("data", 32'(pout[k][7:0]), 32'(m_dat[k]));
          end
        end
      end
    end
  end

  bit rand_cpu = 1'b0;
  bit aborted;
  int first_lat;
  logic [7:0] got_dat [$];
  logic [31:0] got_addr [$];

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_cpu) begin
      cpu_rst = 1'($urandom); mw = 1'($urandom); mr2 = 1'($urandom);
      a2 = $urandom; sz = 2'($urandom); sg = 1'($urandom);
    end
  endtask

  // STM32 side: request, take each byte, optionally abort by dropping REQ shortly after a READ
  task automatic run_xfer(input int k, input int abort_byte, input bit rnd);
    int lim, lat;
    got_dat.delete();
    got_addr.delete();
    aborted = 1'b0;
    lat = 1;
    ctl[k] = 2'b01;
    for (int b = 0; b < NBYTES; b++) begin
      if (b == 0) tick();
      if (b < DEPTH) begin
        lim = 0;
        while (!p_mr[k] && lim < 40) begin tick(); lim++; end
        chk("read_wait", 32'(lim < 40), 32'h1);
        if (b == 0) lat = lat + lim;
      end
      if (b == abort_byte) begin
        repeat (rnd ? $urandom_range(1, 3) : 1) tick();
        ctl[k][0] = 1'b0;
        tick();
        aborted = 1'b1;
        return;
      end
      lim = 0;
      while (!pout[k][8] && lim < 60) begin tick(); lim++; end
      chk("valid_wait", 32'(lim < 60), 32'h1);
      if (b == 0) first_lat = lat + lim;
      got_dat.push_back(pout[k][7:0]);
      got_addr.push_back(p_a[k]);
      if (rnd) repeat ($urandom_range(0, 3)) tick();
      ctl[k][1] = 1'b1;
      repeat (rnd ? $urandom_range(1, 3) : 1) tick();
      ctl[k][1] = 1'b0;
      tick();
    end
    lim = 0;
    while (!pout[k][9] && lim < 20) begin tick(); lim++; end
    chk("done_wait", 32'(lim < 20), 32'h1);
  endtask

  initial begin
    ctl[0] = 2'b00; ctl[1] = 2'b00;
    cpu_rst = 1'b1; mw = 1'b0; mr2 = 1'b0; a2 = 32'h0; sz = 2'b00; sg = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h0F;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Idle passthrough
    a2 = 32'h1234; mr2 = 1'b1; cpu_rst = 1'b0;
    #1;
    chk("lit_pass_addr", p_a[0], 32'h1234);
    chk("lit_pass_rd", 32'(p_mr[0]), 32'h1);
    chk("lit_pass_rst", 32'(p_rst[0]), 32'h0);
    chk("lit_pass_out", 32'(pout[0]), 32'h0);
    tick();

    // Full readback, MEM_LAT=1
    run_xfer(0, -1, 1'b0);
    chk("lit_n_bytes", 32'(got_dat.size()), 32'(NBYTES));
    if (got_dat.size() >= 3) begin
      chk("lit_byte0", 32'(got_dat[0]), 32'hA5);
      chk("lit_byte1", 32'(got_dat[1]), 32'h3C);
      chk("lit_byte2", 32'(got_dat[2]), 32'h0F);
      chk("lit_addr0", got_addr[0], 32'h0);
      chk("lit_addr1", got_addr[1], 32'h1);
      chk("lit_addr2", got_addr[2], 32'h2);
    end
    if (CSUM != 0 && got_dat.size() >= 4) chk("lit_csum", 32'(got_dat[3]), 32'hF0);
    chk("lit_valid_lat1", 32'(first_lat), 32'd3);
    chk("lit_done", 32'(pout[0][9:8]), 32'h2);
    ctl[0][0] = 1'b0;
    tick();
    chk("lit_release_rst", 32'(p_rst[0]), 32'h1);
    chk("lit_release_out", 32'(pout[0]), 32'h0);
    tick();
    chk("lit_after_rel_rst", 32'(p_rst[0]), 32'h0);
    chk("lit_after_rel_addr", p_a[0], 32'h1234);

    // Abort in WAIT of the second byte, MEM_LAT=3, then restart
    run_xfer(1, 1, 1'b0);
    chk("lit_abort_rst", 32'(p_rst[1]), 32'h1);
    chk("lit_abort_out", 32'(pout[1]), 32'h0);
    tick();
    chk("lit_abort_idle_rst", 32'(p_rst[1]), 32'h0);
    run_xfer(1, -1, 1'b0);
    if (got_addr.size() >= 1) chk("lit_restart_addr", got_addr[0], 32'h0);
    if (got_dat.size() >= 3) chk("lit_lat3_byte2", 32'(got_dat[2]), 32'h0F);
    chk("lit_valid_lat3", 32'(first_lat), 32'd5);
    ctl[1][0] = 1'b0;
    tick(); tick();

    // Reset while PRESENT with ACK held through and after reset
    ctl[0] = 2'b01;
    begin
      int lim = 0;
      while (!pout[0][8] && lim < 40) begin tick(); lim++; end
      chk("rst_valid_wait", 32'(lim < 40), 32'h1);
    end
    ctl[0][1] = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("lit_rst_out", 32'(pout[0]), 32'h0);
    chk("lit_rst_pass", p_a[0], 32'h1234);
    rst_n = 1'b1;
    begin
      int lim = 0;
      while (!pout[0][8] && lim < 40) begin tick(); lim++; end
      chk("rst_revalid_wait", 32'(lim < 40), 32'h1);
    end
    repeat (4) tick();
    chk("lit_held_ack", 32'(pout[0][8]), 32'h1);
    ctl[0][1] = 1'b0;
    tick();
    ctl[0][1] = 1'b1;
    tick();
    chk("lit_ack_after_rise", 32'(pout[0][8]), 32'h0);
    ctl[0] = 2'b00;
    tick(); tick();

    // Random transfers with random aborts, ACK timing, memory contents and CPU-side traffic
    rand_cpu = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 2; k++) begin
        int ab;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NBYTES - 1)) : -1;
        run_xfer(k, ab, 1'b1);
        if (!aborted) begin
          ctl[k][0] = 1'b0;
          tick();
        end
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
